alu_result_buffer: RTL
======================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of result entries (power of two, 2..16).
REQ-002 Parameter CW, default 8, SHALL set the width of the popped-result counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset; it SHALL be sampled on the rising edge of clk only.
REQ-005 in_valid  input  1  SHALL mark the upstream ALU result as valid this cycle.
REQ-006 in_y  input  5  SHALL carry the ALU result: bit 4 is carry/borrow, bits 3:0 are data.
REQ-007 in_sel  input  4  SHALL carry the ALU opcode that produced in_y, stored as a tag.
REQ-008 in_ready  output  1  SHALL be high when a result can be accepted this cycle.
REQ-009 out_valid  output  1  SHALL be high when the head entry is presented.
REQ-010 out_ready  input  1  SHALL be high when the consumer takes the head entry.
REQ-011 out_y, out_sel  output  5, 4  SHALL present the head entry's result and tag.
REQ-012 out_zero, out_carry  output  1, 1  SHALL present the head entry's flags.
REQ-013 count  output  clog2(DEPTH)+1  SHALL give the number of stored entries.
REQ-014 res_cnt  output  CW  SHALL count popped entries.

Function
REQ-015 Push SHALL occur on a rising edge where in_valid && in_ready.
REQ-016 Pop SHALL occur on a rising edge where out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), combinationally from state only; there is no pass-through when full.
REQ-018 out_valid SHALL equal (count != 0), combinationally from state only.
REQ-019 Flags SHALL be computed at push time and stored with the entry: zero = (in_y[3:0] == 0), carry = in_y[4].
REQ-020 Ordering SHALL be first-in first-out; the head entry SHALL be presented first-word-fall-through.
REQ-021 Latency SHALL be 1 cycle: a push into an empty buffer SHALL make out_valid high on the following cycle.
REQ-022 out_y, out_sel, out_zero and out_carry SHALL be driven to 0 whenever out_valid is low.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged, and the order SHALL be preserved.
REQ-024 When count == DEPTH, in_ready SHALL be 0, so a pop alone occurs and count decrements.
REQ-025 When count == 0, no pop occurs and out_ready is ignored.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 count SHALL never exceed DEPTH or go below 0.
REQ-028 res_cnt SHALL increment by 1 per pop and wrap from 2^CW-1 to 0 without stalling.
REQ-029 in_y and in_sel SHALL be ignored when in_valid is low.
REQ-030 out_ready SHALL be ignored when out_valid is low.
REQ-031 Held data SHALL remain stable while out_valid && !out_ready.

Reset
REQ-032 While rst is high at a clock edge, all of the following SHALL be cleared on that edge: pointers, count and res_cnt to 0.
REQ-033 While rst is high, out_valid SHALL be 0 and in_ready SHALL be 1 from the cycle after that edge.
REQ-034 Reset mid-operation SHALL discard all stored entries; no push or pop SHALL take effect on a reset edge.
REQ-035 Stored entry contents need not be cleared, because REQ-022 masks them.

Verification
REQ-036 Reset then single push: in_y=01100, in_sel=0000 -> next cycle out_valid=1, out_y=01100, out_zero=0, out_carry=0, count=1.
REQ-037 Fill to full: push 10011, 10000, 00101, 00000 with out_ready=0 -> count=4, in_ready=0; a fifth push is not accepted.
REQ-038 Drain after fill: out_ready=1 -> heads in order 10011 (carry=1), 10000 (zero=1, carry=1), 00101, 00000 (zero=1); then out_valid=0, outputs 0, res_cnt=4.
REQ-039 Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, FIFO order matches the scoreboard, res_cnt=10.
REQ-040 Reset asserted with count=3 -> next cycle count=0, out_valid=0, in_ready=1, res_cnt=0; a push that cycle is dropped.
REQ-041 Wrap: with CW=8, perform 256 pops -> res_cnt=0; the pointers wrap with no data corruption.

Source files
------------

// File: rtl/alu_result_buffer.sv
// First-word-fall-through FIFO for ALU results: each entry holds the result,
// its opcode tag and the zero/carry flags captured when the entry was pushed.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [4:0]               in_y,
    input  logic [3:0]               in_sel,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_y,
    output logic [3:0]               out_sel,
    output logic                     out_zero,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CW-1:0]            res_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH)+1)'(DEPTH);

    typedef struct packed {
        logic       zero;
        logic       carry;
        logic [3:0] sel;
        logic [4:0] y;
    } entry_t;

    entry_t                  r_mem [DEPTH];
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [$clog2(DEPTH):0]  r_cnt;
    logic [CW-1:0]           r_res;

    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    assign in_ready  = (r_cnt != FULL);
    assign out_valid = (r_cnt != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Entry storage is never cleared; the output mask hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr] <= '{zero: (in_y[3:0] == 4'd0), carry: in_y[4], sel: in_sel, y: in_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd  <= r_rd + 1'b1;
                r_res <= r_res + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_head    = out_valid ? r_mem[r_rd] : '0;
    assign out_y     = w_head.y;
    assign out_sel   = w_head.sel;
    assign out_zero  = w_head.zero;
    assign out_carry = w_head.carry;
    assign count     = r_cnt;
    assign res_cnt   = r_res;

endmodule
